// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown reload timer and its
// next-count calculator.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Terminal count is detected one step early so the counter never wraps.
  localparam int unsigned TC_VALUE = 1;

  function automatic logic is_active(input state_t s);
    return s == RUN;
  endfunction

endpackage

// File: rtl/countdown_next.sv
// Combinational next-count, terminal-count and borrow-out calculator for
// one stage of the countdown timer.
module countdown_next
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_bin,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc,
  output logic             o_zero,
  output logic             o_bout
);

  logic w_zero;

  assign w_zero = (i_count == '0);
  assign o_zero = w_zero;
  assign o_next = i_count - WIDTH'(1);
  assign o_tc   = (i_count == WIDTH'(TC_VALUE));

  // Borrow depends only on the count register and bin to keep the cascade path short.
  assign o_bout = i_bin & w_zero;

endmodule

// File: rtl/countdown_reload_timer.sv
// Loadable down-counter with borrow-in/borrow-out, optional auto-reload and
// a three-state run control; cascades through the combinational borrow chain.
module countdown_reload_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter bit          AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             bin,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             done,
  output logic             busy,
  output logic             expired
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             r_busy;
  logic             r_expired;

  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  logic             w_zero;
  logic             w_bout;

  countdown_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_count(r_out),
    .i_bin  (bin),
    .o_next (w_next),
    .o_tc   (w_tc),
    .o_zero (w_zero),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_out    <= data;
        r_reload <= data;
        // A non-zero load while running keeps the timer running from the new value.
        if (!(is_active(r_state) && (data != '0))) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_expired <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !w_zero) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (bin) begin
              if (w_tc) begin
                r_done <= 1'b1;
                if (AUTO_RELOAD) begin
                  r_out <= r_reload;
                end else begin
                  r_out     <= '0;
                  r_state   <= EXPIRED;
                  r_busy    <= 1'b0;
                  r_expired <= 1'b1;
                end
              end else begin
                r_out <= w_next;
              end
            end
          end
          EXPIRED: begin
            if (start && (r_reload != '0)) begin
              r_out     <= r_reload;
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_expired <= 1'b0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out     = r_out;
  assign bout    = w_bout;
  assign done    = r_done;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_reload_timer.sv
// Directed self-checking bench for countdown_reload_timer: auto-reload, one-shot,
// priority cases, a two-stage borrow cascade and mid-count reset.
module tb_countdown_reload_timer;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_data, b_data, c_data, h_data;
  logic       a_load, a_start, a_stop, a_bin;
  logic       b_load, b_start, b_stop, b_bin;
  logic       c_load, c_start, c_stop, c_bin;
  logic       h_load, h_start, h_stop;
  logic [7:0] a_out, b_out, c_out, h_out;
  logic       a_bout, a_done, a_busy, a_expired;
  logic       b_bout, b_done, b_busy, b_expired;
  logic       c_bout, c_done, c_busy, c_expired;
  logic       h_bout, h_done, h_busy, h_expired;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  logic [7:0] t1_out [6] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
  logic       t1_done[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] t5_cout[6] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd5, 8'd4};

  countdown_reload_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .data(a_data), .load(a_load), .start(a_start),
    .stop(a_stop), .bin(a_bin), .out(a_out), .bout(a_bout), .done(a_done),
    .busy(a_busy), .expired(a_expired));

  countdown_reload_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .data(b_data), .load(b_load), .start(b_start),
    .stop(b_stop), .bin(b_bin), .out(b_out), .bout(b_bout), .done(b_done),
    .busy(b_busy), .expired(b_expired));

  countdown_reload_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .data(c_data), .load(c_load), .start(c_start),
    .stop(c_stop), .bin(c_bin), .out(c_out), .bout(c_bout), .done(c_done),
    .busy(c_busy), .expired(c_expired));

  countdown_reload_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .data(h_data), .load(h_load), .start(h_start),
    .stop(h_stop), .bin(c_bout), .out(h_out), .bout(h_bout), .done(h_done),
    .busy(h_busy), .expired(h_expired));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic cmp(input logic [31:0] obs);
    sb_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic run_a(input string tag, input logic [7:0] eo,
                       input logic ed, input logic eb, input logic ex);
    push({tag, ".out"}, 32'(eo));
    push({tag, ".done"}, 32'(ed));
    push({tag, ".busy"}, 32'(eb));
    push({tag, ".expired"}, 32'(ex));
    tick();
    cmp(32'(a_out)); cmp(32'(a_done)); cmp(32'(a_busy)); cmp(32'(a_expired));
  endtask

  task automatic run_b(input string tag, input logic [7:0] eo,
                       input logic ed, input logic eb, input logic ex);
    push({tag, ".out"}, 32'(eo));
    push({tag, ".done"}, 32'(ed));
    push({tag, ".busy"}, 32'(eb));
    push({tag, ".expired"}, 32'(ex));
    tick();
    cmp(32'(b_out)); cmp(32'(b_done)); cmp(32'(b_busy)); cmp(32'(b_expired));
  endtask

  initial begin
    rst_n = 1'b0;
    a_data = '0; a_load = 0; a_start = 0; a_stop = 0; a_bin = 0;
    b_data = '0; b_load = 0; b_start = 0; b_stop = 0; b_bin = 0;
    c_data = '0; c_load = 0; c_start = 0; c_stop = 0; c_bin = 0;
    h_data = '0; h_load = 0; h_start = 0; h_stop = 0;

    // Reset held for two edges
    tick();
    run_a("rst", 8'd0, 1'b0, 1'b0, 1'b0);
    push("rst.bout", 32'd0); cmp(32'(a_bout));

    // 1: auto-reload period of 3
    rst_n = 1'b1;
    a_load = 1; a_data = 8'd3;
    run_a("t1_load", 8'd3, 1'b0, 1'b0, 1'b0);
    a_load = 0; a_start = 1; a_bin = 1;
    run_a("t1_start", 8'd3, 1'b0, 1'b1, 1'b0);
    a_start = 0;
    for (int i = 0; i < 6; i++) run_a("t1_run", t1_out[i], t1_done[i], 1'b1, 1'b0);

    // 3: reload while running, stop/resume, bin gating
    a_load = 1; a_data = 8'd5;
    run_a("t3_load_run", 8'd5, 1'b0, 1'b1, 1'b0);
    a_load = 0;
    run_a("t3_dec4", 8'd4, 1'b0, 1'b1, 1'b0);
    run_a("t3_dec3", 8'd3, 1'b0, 1'b1, 1'b0);
    a_stop = 1;
    run_a("t3_stop", 8'd3, 1'b0, 1'b0, 1'b0);
    a_stop = 0;
    run_a("t3_hold", 8'd3, 1'b0, 1'b0, 1'b0);
    a_start = 1;
    run_a("t3_resume", 8'd3, 1'b0, 1'b1, 1'b0);
    a_start = 0; a_bin = 1;
    run_a("t3_bin1", 8'd2, 1'b0, 1'b1, 1'b0);
    a_bin = 0;
    run_a("t3_bin0", 8'd2, 1'b0, 1'b1, 1'b0);
    a_bin = 1;
    run_a("t3_bin1b", 8'd1, 1'b0, 1'b1, 1'b0);
    a_stop = 1;
    run_a("t4_stop_tc", 8'd1, 1'b0, 1'b0, 1'b0);
    a_stop = 0;

    // 4: priority cases
    a_load = 1; a_start = 1; a_data = 8'd9;
    run_a("t4_load_start", 8'd9, 1'b0, 1'b0, 1'b0);
    a_load = 0;
    run_a("t4_start", 8'd9, 1'b0, 1'b1, 1'b0);
    a_start = 0; a_load = 1; a_data = 8'd0;
    run_a("t4_load0_run", 8'd0, 1'b0, 1'b0, 1'b0);
    push("t4_bout_zero", 32'd1); cmp(32'(a_bout));
    a_load = 0; a_start = 1;
    run_a("t4_start_zero", 8'd0, 1'b0, 1'b0, 1'b0);
    a_start = 0; a_load = 1; a_data = 8'd2;
    run_a("t4_load2", 8'd2, 1'b0, 1'b0, 1'b0);
    a_load = 0; a_start = 1;
    run_a("t4_start2", 8'd2, 1'b0, 1'b1, 1'b0);
    a_start = 0;
    run_a("t4_at_tc", 8'd1, 1'b0, 1'b1, 1'b0);
    a_load = 1; a_data = 8'd6;
    run_a("t4_load_tc", 8'd6, 1'b0, 1'b1, 1'b0);
    a_load = 0; a_stop = 1;
    run_a("t4_stop6", 8'd6, 1'b0, 1'b0, 1'b0);
    a_stop = 0;

    // 2: one-shot instance
    b_load = 1; b_data = 8'd2;
    run_b("t2_load", 8'd2, 1'b0, 1'b0, 1'b0);
    b_load = 0; b_start = 1; b_bin = 1;
    run_b("t2_start", 8'd2, 1'b0, 1'b1, 1'b0);
    run_b("t2_start_in_run", 8'd1, 1'b0, 1'b1, 1'b0);
    b_start = 0;
    run_b("t2_tc", 8'd0, 1'b1, 1'b0, 1'b1);
    run_b("t2_expired", 8'd0, 1'b0, 1'b0, 1'b1);
    run_b("t2_expired_hold", 8'd0, 1'b0, 1'b0, 1'b1);
    b_start = 1;
    run_b("t2_restart", 8'd2, 1'b0, 1'b1, 1'b0);
    b_start = 0;
    run_b("t2_redec", 8'd1, 1'b0, 1'b1, 1'b0);
    run_b("t2_retc", 8'd0, 1'b1, 1'b0, 1'b1);

    // 5: two-stage borrow cascade
    h_load = 1; h_data = 8'd4;
    push("t5_hi_load", 32'd4); tick(); cmp(32'(h_out));
    h_load = 0; h_start = 1;
    push("t5_hi_out", 32'd4); push("t5_hi_busy", 32'd1);
    tick(); cmp(32'(h_out)); cmp(32'(h_busy));
    h_start = 0; c_bin = 1;
    #1;
    push("t5_bout_comb", 32'd1); cmp(32'(c_bout));
    push("t5_hi_dec", 32'd3); tick(); cmp(32'(h_out));
    c_load = 1; c_data = 8'd5;
    #1;
    push("t5_bout_vs_load", 32'd1); cmp(32'(c_bout));
    push("t5_lo_load", 32'd5); push("t5_hi_dec2", 32'd2);
    tick(); cmp(32'(c_out)); cmp(32'(h_out));
    c_load = 0;
    #1;
    push("t5_bout_nz", 32'd0); cmp(32'(c_bout));
    c_start = 1;
    push("t5_lo_busy", 32'd1); push("t5_hi_hold", 32'd2);
    tick(); cmp(32'(c_busy)); cmp(32'(h_out));
    c_start = 0;
    for (int i = 0; i < 6; i++) begin
      push("t5_lo_out", 32'(t5_cout[i]));
      push("t5_lo_bout", 32'd0);
      push("t5_hi_still", 32'd2);
      tick(); cmp(32'(c_out)); cmp(32'(c_bout)); cmp(32'(h_out));
    end

    // 6: reset mid-count
    a_load = 1; a_data = 8'd7;
    run_a("t6_load", 8'd7, 1'b0, 1'b0, 1'b0);
    a_load = 0; a_start = 1; a_bin = 1;
    run_a("t6_run", 8'd7, 1'b0, 1'b1, 1'b0);
    a_start = 0; rst_n = 1'b0;
    run_a("t6_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_a("t6_after", 8'd0, 1'b0, 1'b0, 1'b0);
    run_a("t6_after2", 8'd0, 1'b0, 1'b0, 1'b0);

    if (sb_q.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_reload_timer.md
Name: countdown_reload_timer

Overview:
Loadable down-counter with borrow-in/borrow-out and an optional auto-reload. It is the decrementing counterpart of the team's 8-bit loadable up-counter with carry-in/carry-out. Used as a programmable interval timer. Cascades with identical instances through a combinational borrow chain, matching the up-counter's carry chain.

Parameters:
WIDTH, 8, counter and load-data width in bits
AUTO_RELOAD, 1, 1 = reload from the stored value at terminal count and keep running; 0 = stop at zero (one-shot)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
data  input  WIDTH  load value
load  input  1  load data into count and reload registers
start  input  1  begin or resume counting
stop  input  1  halt counting, hold count
bin  input  1  borrow-in / decrement enable; tie to 1 for a standalone timer
out  output  WIDTH  current count (registered)
bout  output  1  borrow-out to next stage (combinational)
done  output  1  one-cycle pulse on terminal count (registered)
busy  output  1  high in RUN (registered)
expired  output  1  high in EXPIRED (registered)

Behaviour:
- Reset (rst_n=0 at a clk edge): out=0, reload_q=0, state=IDLE, done=0, busy=0, expired=0. Reset overrides every other input, including mid-count.
- States: IDLE, RUN, EXPIRED. busy=(state==RUN), expired=(state==EXPIRED).
- Per-cycle priority: load > stop > start > decrement.
- load:
  - out<=data, reload_q<=data.
  - From IDLE or EXPIRED: next state IDLE.
  - From RUN: stays RUN if data!=0, else goes to IDLE.
  - Never asserts done.
- stop in RUN: next state IDLE, out held. Ignored in IDLE and EXPIRED.
- start in IDLE: go to RUN if out!=0, else ignored.
- start in EXPIRED:
  - If reload_q!=0: out<=reload_q, state RUN.
  - Otherwise stay EXPIRED.
- start while already in RUN: no effect.
- RUN with bin=1 and no load/stop:
  - If out>1: out<=out-1.
  - If out==1 (terminal count): done=1 next cycle for exactly one cycle. Then:
    - AUTO_RELOAD=1: out<=reload_q, stay RUN.
    - AUTO_RELOAD=0: out<=0, state EXPIRED.
- RUN with bin=0: out held, no done.
- Period: with AUTO_RELOAD=1 and bin=1 each cycle, done pulses every reload_q cycles.
- bout = bin & (out==0), purely combinational from the out register and bin.
  - Independent of state, load, stop and start, so the borrow path stays short (same timing rule as the up-counter's carry-out).
  - Cascade: stage N+1 bin = stage N bout.
- Arithmetic: decrement is modulo 2^WIDTH but never wraps in RUN, because terminal count is detected at 1.
- Simultaneous events:
  - load+start: load wins, start ignored that cycle.
  - stop+terminal count: stop wins, out held at 1, no done.
  - load at terminal count: load wins, no done.
- Outputs change only on clk edges, except bout.

Decomposition:
- Shared package countdown_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2)
  - default WIDTH constant
  - a TC_VALUE constant (1)
- One natural sub-module: countdown_next, a combinational next-count/borrow calculator (next out, terminal-count flag, bout). The top holds the registers and the FSM.

Test Plan:
1. Reset and load: rst_n=0 for 2 cycles -> all outputs 0. Then load with data=8'd3, start, bin=1 -> out 3,2,1,3,2,1...; done pulses once every 3 cycles; busy=1 throughout.
2. One-shot: AUTO_RELOAD=0, load 8'd2, start, bin=1 -> out 2,1,0; done=1 for one cycle; then expired=1, busy=0, out stays 0. A later start -> out=2, RUN.
3. Stop/resume and bin gating: load 8'd5, start, bin=1 for 2 cycles (out=3), stop -> out held at 3, IDLE. bin toggled 1,0,1 after start -> out 2,2,1.
4. Priority: load(data=8'd9)+start in the same cycle -> out=9, IDLE. stop at out=1 -> no done, out=1. load 0 in RUN -> IDLE; start ignored.
5. Borrow chain: two instances cascaded (low bout -> high bin), low=0, high=8'd4, low bin=1 -> low bout=1 combinationally. Verify high stage out 4->3, assert bout does not depend on load, and bout stays 0 while low!=0.
6. Reset mid-count: RUN at out=8'd7, rst_n=0 for one edge -> out=0, IDLE, done=0 at the next edge. No residual done pulse after reset release.
